prbs6_checker: RTL and testbench

Receive-side companion to the 6-bit LFSR value generator in `top`. It consumes the generated 6-bit value stream and self-synchronises to it. Once locked, it predicts every following value and counts mismatches. It sits beside `top` in the project so that the generator's output can be checked in hardware, and by the bench, without a golden model.

---
 rtl/prbs6_pkg.sv | 23 ++
 rtl/prbs6_step.sv | 16 +
 rtl/prbs6_checker.sv | 145 ++++++++++++++
 tb/tb_prbs6_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs6_pkg.sv
// rtl/prbs6_pkg.sv - shared PRBS6 constants, step function and checker state encoding
//
// Purpose: single source of truth for the x^6+x^5+1 LFSR used by the generator
// (top) and the receive-side checker (prbs6_checker), so the two cannot diverge.
// Contents: value width, tap positions, prbs6_next(), checker state_t.
package prbs6_pkg;

    localparam int PRBS6_W     = 6;
    localparam int PRBS6_TAP_A = 5;   // x^6 term feeds back from bit 5
    localparam int PRBS6_TAP_B = 4;   // x^5 term feeds back from bit 4

    typedef enum logic [0:0] {
        ST_SEEK   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Left shift with the XOR of the two taps entering at bit 0; period 63,
    // and 0 maps to itself (the lockup value).
    function automatic logic [PRBS6_W-1:0] prbs6_next(input logic [PRBS6_W-1:0] v);
        return {v[PRBS6_W-2:0], v[PRBS6_TAP_A] ^ v[PRBS6_TAP_B]};
    endfunction

endpackage

// File: rtl/prbs6_step.sv
// rtl/prbs6_step.sv - combinational PRBS6 next-value block
//
// Purpose: computes the successor of a 6-bit LFSR value.
// Ports:
//   cur_value  in  6  current value
//   next_value out 6  prbs6_next(cur_value)
module prbs6_step
    import prbs6_pkg::*;
(
    input  logic [PRBS6_W-1:0] cur_value,
    output logic [PRBS6_W-1:0] next_value
);

    assign next_value = prbs6_next(cur_value);

endmodule

// File: rtl/prbs6_checker.sv
// rtl/prbs6_checker.sv - self-synchronising PRBS6 stream checker with error counting
//
// Purpose: locks onto a stream of PRBS6 generator values, then predicts each
// following value and counts mismatches; drops back to seeking after
// LOSS_CNT consecutive mismatches.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      in_value carries a sample this cycle
//   in_value   in  6      received generator value
//   locked     out 1      synchronised to the stream
//   err_pulse  out 1      one-cycle flag per mismatched sample while locked
//   err_count  out ERR_W  saturating count of mismatches while locked
//   seek_count out 4      saturating count of lock losses
module prbs6_checker
    import prbs6_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PRBS6_W-1:0]   in_value,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_count,
    output logic [3:0]           seek_count
);

    localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_V = 4'(LOSS_CNT);

    state_t               state_q, state_d;
    logic                 have_prev_q, have_prev_d;
    logic [3:0]           good_run_q, good_run_d;
    logic [3:0]           bad_run_q, bad_run_d;
    logic [PRBS6_W-1:0]   prev_q, prev_d;
    logic [PRBS6_W-1:0]   expected_q, expected_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic [3:0]           seek_count_q, seek_count_d;

    logic [PRBS6_W-1:0]   prev_next;
    logic [PRBS6_W-1:0]   expected_next;

    prbs6_step u_step_prev (
        .cur_value  (prev_q),
        .next_value (prev_next)
    );

    prbs6_step u_step_expected (
        .cur_value  (expected_q),
        .next_value (expected_next)
    );

    always_comb begin
        state_d      = state_q;
        have_prev_d  = have_prev_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        prev_d       = prev_q;
        expected_d   = expected_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        seek_count_d = seek_count_q;

        if (in_valid) begin
            case (state_q)
                ST_SEEK: begin
                    have_prev_d = 1'b1;
                    prev_d      = in_value;
                    if (have_prev_q && (in_value == prev_next) && (in_value != '0)) begin
                        if (good_run_q + 4'd1 == LOCK_CNT_V) begin
                            state_d    = ST_LOCKED;
                            expected_d = prbs6_next(in_value);
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            good_run_d = good_run_q + 4'd1;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                default: begin
                    // Prediction free-runs from the locked state so one corrupted
                    // sample costs exactly one error.
                    expected_d = expected_next;
                    if ((in_value != expected_q) || (in_value == '0)) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (bad_run_q + 4'd1 == LOSS_CNT_V) begin
                            state_d     = ST_SEEK;
                            prev_d      = in_value;
                            have_prev_d = 1'b1;
                            good_run_d  = '0;
                            bad_run_d   = '0;
                            if (seek_count_q != 4'hF) begin
                                seek_count_d = seek_count_q + 4'd1;
                            end
                        end else begin
                            bad_run_d = bad_run_q + 4'd1;
                        end
                    end else begin
                        bad_run_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEEK;
            have_prev_q  <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            prev_q       <= '0;
            expected_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            seek_count_q <= '0;
        end else begin
            state_q      <= state_d;
            have_prev_q  <= have_prev_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            prev_q       <= prev_d;
            expected_q   <= expected_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            seek_count_q <= seek_count_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign seek_count = seek_count_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// tb/tb_prbs6_checker.sv - directed table-driven bench for prbs6_checker
module tb_prbs6_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_value;

    logic        locked_a, err_pulse_a;
    logic [15:0] err_count_a;
    logic [3:0]  seek_count_a;
    logic        locked_b, err_pulse_b;
    logic [1:0]  err_count_b;
    logic [3:0]  seek_count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs6_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .locked     (locked_a),
        .err_pulse  (err_pulse_a),
        .err_count  (err_count_a),
        .seek_count (seek_count_a)
    );

    prbs6_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .locked     (locked_b),
        .err_pulse  (err_pulse_b),
        .err_count  (err_count_b),
        .seek_count (seek_count_b)
    );

    typedef struct {
        logic        v;
        logic [5:0]  val;
        logic        l;
        logic        p;
        logic [15:0] e;
        logic [3:0]  s;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [5:0] val, input logic l,
                       input logic p, input logic [15:0] e, input logic [3:0] s);
        vec_t t;
        t.v = v; t.val = val; t.l = l; t.p = p; t.e = e; t.s = s;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs away from the edge, then sample just after it.
    task automatic drive(input logic v, input logic [5:0] val);
        @(negedge clk);
        in_valid = v;
        in_value = val;
        @(posedge clk);
        #1;
    endtask

    // One reset cycle with a valid sample present; it must be discarded.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_value = 6'd2;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " locked"},     32'(locked_a),     32'd0);
        check({tag, " err_pulse"},  32'(err_pulse_a),  32'd0);
        check({tag, " err_count"},  32'(err_count_a),  32'd0);
        check({tag, " seek_count"}, 32'(seek_count_a), 32'd0);
    endtask

    task automatic acquire();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 6'(1 << k));
        end
    endtask

    initial begin
        logic ever_locked;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = 6'd0;

        // Reset state
        do_reset();
        check_zero("reset");

        // Main table: acquisition, single error, run clearing, lock loss, relock, gaps
        add(1, 1,  0, 0, 0, 0);
        add(1, 2,  0, 0, 0, 0);
        add(1, 4,  0, 0, 0, 0);
        add(1, 8,  0, 0, 0, 0);
        add(1, 16, 1, 0, 0, 0);   // 4th good successor -> locked
        add(1, 0,  1, 1, 1, 0);   // 0 in place of 33
        add(1, 3,  1, 0, 1, 0);
        add(1, 6,  1, 0, 1, 0);
        add(1, 12, 1, 0, 1, 0);
        add(1, 5,  1, 1, 2, 0);   // expected 24
        add(0, 63, 1, 0, 2, 0);   // gap: pulse drops, nothing else moves
        add(1, 5,  1, 1, 3, 0);   // expected 49
        add(1, 5,  0, 1, 4, 1);   // third consecutive mismatch -> seek
        add(1, 1,  0, 0, 4, 1);   // mismatches f(5)=10, restarts run
        add(1, 2,  0, 0, 4, 1);
        add(1, 4,  0, 0, 4, 1);
        add(1, 8,  0, 0, 4, 1);
        add(1, 16, 1, 0, 4, 1);
        add(0, 33, 1, 0, 4, 1);   // correct value but invalid: ignored
        add(0, 0,  1, 0, 4, 1);
        add(1, 33, 1, 0, 4, 1);
        add(1, 0,  1, 1, 5, 1);   // in place of 3
        add(1, 0,  1, 1, 6, 1);   // in place of 6
        add(1, 12, 1, 0, 6, 1);   // match clears bad run
        add(1, 0,  1, 1, 7, 1);   // in place of 24
        add(1, 0,  1, 1, 8, 1);   // in place of 49
        add(1, 0,  0, 1, 9, 2);   // in place of 34 -> seek again

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].val);
            check($sformatf("vec%0d locked", i),     32'(locked_a),     32'(tbl[i].l));
            check($sformatf("vec%0d err_pulse", i),  32'(err_pulse_a),  32'(tbl[i].p));
            check($sformatf("vec%0d err_count", i),  32'(err_count_a),  32'(tbl[i].e));
            check($sformatf("vec%0d seek_count", i), 32'(seek_count_a), 32'(tbl[i].s));
        end

        // Zero stream then constant 7: never locks, no errors counted
        do_reset();
        ever_locked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'd0);
            ever_locked |= locked_a;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'd7);
            ever_locked |= locked_a;
        end
        check("garbage ever_locked", 32'(ever_locked), 32'd0);
        check("garbage err_count",   32'(err_count_a), 32'd0);

        // Acquisition with 3-cycle gaps carrying tempting junk
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 6'(1 << k));
            check($sformatf("gap k%0d locked", k), 32'(locked_a), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                drive(1'b0, 6'(1 << (k + 1)));
                drive(1'b0, 6'd0);
                drive(1'b0, 6'd63);
                check($sformatf("gap k%0d idle locked", k), 32'(locked_a), 32'd0);
            end
        end
        check("gap err_count", 32'(err_count_a), 32'd0);

        // Reset while locked with err_count=2
        do_reset();
        acquire();
        drive(1'b1, 6'd0);   // in place of 33
        drive(1'b1, 6'd0);   // in place of 3
        check("midrst pre err_count", 32'(err_count_a), 32'd2);
        check("midrst pre locked",    32'(locked_a),    32'd1);
        do_reset();
        check_zero("midrst");
        drive(1'b1, 6'd4);   // first sample after reset only primes prev
        check("midrst post locked", 32'(locked_a), 32'd0);

        // Saturation on the ERR_W=2 instance: five isolated errors
        do_reset();
        acquire();
        check("sat locked_b", 32'(locked_b), 32'd1);
        begin
            logic [5:0] good_vals [5];
            good_vals = '{6'd3, 6'd12, 6'd49, 6'd5, 6'd20};
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 6'd0);
                check($sformatf("sat e%0d err_count_b", i), 32'(err_count_b),
                      (i < 3) ? 32'(i + 1) : 32'd3);
                check($sformatf("sat e%0d err_pulse_b", i), 32'(err_pulse_b), 32'd1);
                drive(1'b1, good_vals[i]);
                check($sformatf("sat g%0d err_pulse_b", i), 32'(err_pulse_b), 32'd0);
            end
        end
        check("sat err_count_b",  32'(err_count_b),  32'd3);
        check("sat locked_b end", 32'(locked_b),     32'd1);
        check("sat err_count_a",  32'(err_count_a),  32'd5);
        check("sat seek_count_b", 32'(seek_count_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
